branch_mistake_tracker: RTL and testbench

- Parametrised successor to the single-bit misprediction latch. Tracks up to DEPTH in-flight branch predictions in program order and compares each against its resolved outcome from the MEM stage.
- On a mismatch it flushes all younger predictions, raises a redirect to fetch, and counts the misprediction.
- Sits between the fetch-stage predictor (enqueue side) and the MEM-stage branch resolution (resolve side). Its redirect output drives the PC-select mux.

---
 rtl/branch_pkg.sv | 18 +
 rtl/branch_fifo.sv | 68 ++++++
 rtl/branch_mistake_tracker.sv | 118 +++++++++++
 tb/tb_branch_mistake_tracker.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared types for the branch misprediction tracker: queue entry layout and FSM states.
package branch_pkg;

    localparam int TAG_W_DEFAULT = 8;
    localparam int TAG_MAX_W     = 16;

    typedef enum logic {
        TRACK    = 1'b0,
        REDIRECT = 1'b1
    } state_e;

    // Tags narrower than TAG_MAX_W are zero-extended; the constant upper bits fold away.
    typedef struct packed {
        logic                 taken;
        logic [TAG_MAX_W-1:0] tag;
    } entry_t;

endpackage

// File: rtl/branch_fifo.sv
// Circular buffer of in-flight predictions with push, pop and a whole-queue flush.
module branch_fifo
    import branch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  entry_t       push_entry,
    input  logic         pop,
    input  logic         flush,
    output entry_t       head,
    output logic         full,
    output logic         empty,
    output logic [PTR_W:0] count
);

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [PTR_W:0]     count_q, count_d;

    // A flush wins over a same-cycle push: that push belongs to the wrong path.
    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            rptr_d  = wptr_q;
            count_d = '0;
        end else begin
            if (push) begin
                mem_d[wptr_q] = push_entry;
                wptr_d        = wptr_q + PTR_W'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + PTR_W'(1);
            end
            count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    assign head  = mem_q[rptr_q];
    assign full  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/branch_mistake_tracker.sv
// Tracks in-flight branch predictions, compares them against MEM-stage outcomes and
// redirects fetch on a misprediction while counting mistakes and flagging protocol errors.
module branch_mistake_tracker
    import branch_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int TAG_W     = TAG_W_DEFAULT,
    parameter int CNT_W     = 16,
    parameter bit HOLD_MODE = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pred_valid,
    input  logic                   pred_taken,
    input  logic [TAG_W-1:0]       pred_tag,
    output logic                   pred_ready,
    input  logic                   res_valid,
    input  logic                   res_taken,
    input  logic [TAG_W-1:0]       res_tag,
    input  logic                   fetch_ack,
    output logic                   redirect,
    output logic                   redirect_taken,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic [CNT_W-1:0]       mispredict_cnt,
    output logic                   err_sticky
);

    state_e           state_q, state_d;
    logic             redirect_q, redirect_d;
    logic             redirect_taken_q, redirect_taken_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    entry_t head;
    entry_t push_entry;
    logic   fifo_full, fifo_empty;
    logic   push, resolve, mistake;

    assign pred_ready      = (state_q == TRACK) && !fifo_full;
    assign push            = pred_valid && pred_ready;
    assign resolve         = res_valid && (state_q == TRACK) && !fifo_empty;
    assign mistake         = resolve && (head.taken != res_taken);
    assign push_entry.taken = pred_taken;
    assign push_entry.tag   = TAG_MAX_W'(pred_tag);

    branch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (resolve && !mistake),
        .flush      (mistake),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (occupancy)
    );

    // A tag mismatch is only a protocol error; the direction alone decides a mistake.
    always_comb begin
        state_d          = state_q;
        redirect_d       = redirect_q;
        redirect_taken_d = redirect_taken_q;
        cnt_d            = cnt_q;
        err_d            = err_q;
        if (res_valid && ((state_q == REDIRECT) || fifo_empty)) begin
            err_d = 1'b1;
        end
        if (resolve && (head.tag != TAG_MAX_W'(res_tag))) begin
            err_d = 1'b1;
        end
        if (mistake && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        case (state_q)
            TRACK: begin
                if (mistake) begin
                    state_d          = REDIRECT;
                    redirect_d       = 1'b1;
                    redirect_taken_d = res_taken;
                end
            end
            REDIRECT: begin
                if (!HOLD_MODE || fetch_ack) begin
                    state_d          = TRACK;
                    redirect_d       = 1'b0;
                    redirect_taken_d = 1'b0;
                end
            end
            default: begin
                state_d    = TRACK;
                redirect_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= TRACK;
            redirect_q       <= 1'b0;
            redirect_taken_q <= 1'b0;
            cnt_q            <= '0;
            err_q            <= 1'b0;
        end else begin
            state_q          <= state_d;
            redirect_q       <= redirect_d;
            redirect_taken_q <= redirect_taken_d;
            cnt_q            <= cnt_d;
            err_q            <= err_d;
        end
    end

    assign redirect       = redirect_q;
    assign redirect_taken = redirect_taken_q;
    assign mispredict_cnt = cnt_q;
    assign err_sticky     = err_q;

endmodule

// File: tb/tb_branch_mistake_tracker.sv
// Directed bench: a hold-mode, a pulse-mode and a 2-bit-counter tracker share one stimulus stream.
module tb_branch_mistake_tracker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       pred_valid = 1'b0, pred_taken = 1'b0;
    logic [7:0] pred_tag = '0;
    logic       res_valid = 1'b0, res_taken = 1'b0;
    logic [7:0] res_tag = '0;
    logic       fetch_ack = 1'b0;

    logic        h_ready, h_redir, h_rtk, h_err;
    logic [2:0]  h_occ;
    logic [15:0] h_cnt;
    logic        p_ready, p_redir, p_rtk, p_err;
    logic [2:0]  p_occ;
    logic [15:0] p_cnt;
    logic        s_ready, s_redir, s_rtk, s_err;
    logic [2:0]  s_occ;
    logic [1:0]  s_cnt;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    branch_mistake_tracker #(.DEPTH(4), .TAG_W(8), .CNT_W(16), .HOLD_MODE(1'b1)) dut_hold (
        .clk(clk), .rst_n(rst_n),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_tag(pred_tag), .pred_ready(h_ready),
        .res_valid(res_valid), .res_taken(res_taken), .res_tag(res_tag), .fetch_ack(fetch_ack),
        .redirect(h_redir), .redirect_taken(h_rtk), .occupancy(h_occ),
        .mispredict_cnt(h_cnt), .err_sticky(h_err)
    );

    branch_mistake_tracker #(.DEPTH(4), .TAG_W(8), .CNT_W(16), .HOLD_MODE(1'b0)) dut_pulse (
        .clk(clk), .rst_n(rst_n),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_tag(pred_tag), .pred_ready(p_ready),
        .res_valid(res_valid), .res_taken(res_taken), .res_tag(res_tag), .fetch_ack(fetch_ack),
        .redirect(p_redir), .redirect_taken(p_rtk), .occupancy(p_occ),
        .mispredict_cnt(p_cnt), .err_sticky(p_err)
    );

    branch_mistake_tracker #(.DEPTH(4), .TAG_W(8), .CNT_W(2), .HOLD_MODE(1'b1)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_tag(pred_tag), .pred_ready(s_ready),
        .res_valid(res_valid), .res_taken(res_taken), .res_tag(res_tag), .fetch_ack(fetch_ack),
        .redirect(s_redir), .redirect_taken(s_rtk), .occupancy(s_occ),
        .mispredict_cnt(s_cnt), .err_sticky(s_err)
    );

    typedef struct {
        logic       pv, pt;
        logic [7:0] ptag;
        logic       rv, rt;
        logic [7:0] rtag;
        logic       ack;
        logic       ready, redir, rtk;
        logic [2:0] occ;
        logic [15:0] cnt;
        logic       err, predir;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic pv, input logic pt, input logic [7:0] ptag,
                                input logic rv, input logic rt, input logic [7:0] rtag,
                                input logic ack, input logic ready, input logic redir,
                                input logic rtk, input logic [2:0] occ, input logic [15:0] cnt,
                                input logic err, input logic predir);
        vec_t v;
        v.pv = pv; v.pt = pt; v.ptag = ptag;
        v.rv = rv; v.rt = rt; v.rtag = rtag; v.ack = ack;
        v.ready = ready; v.redir = redir; v.rtk = rtk;
        v.occ = occ; v.cnt = cnt; v.err = err; v.predir = predir;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs on the falling edge, clock once, then let outputs settle before checking.
    task automatic applyStimulus(input logic pv, input logic pt, input logic [7:0] ptag,
                                 input logic rv, input logic rt, input logic [7:0] rtag,
                                 input logic ack);
        @(negedge clk);
        pred_valid = pv; pred_taken = pt; pred_tag = ptag;
        res_valid = rv; res_taken = rt; res_tag = rtag; fetch_ack = ack;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ack);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, ack);
    endtask

    task automatic doReset();
        pred_valid = 1'b0; pred_taken = 1'b0; pred_tag = '0;
        res_valid = 1'b0; res_taken = 1'b0; res_tag = '0; fetch_ack = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vec_t v;
        int   exp_cnt;

        // pv pt ptag | rv rt rtag | ack || ready redir rtk occ cnt err pulse_redir
        tbl.push_back(mk(1,1,8'h10, 0,0,8'h00, 0, 1,0,0, 3'd1, 16'd0, 0,0));
        tbl.push_back(mk(1,1,8'h11, 0,0,8'h00, 0, 1,0,0, 3'd2, 16'd0, 0,0));
        tbl.push_back(mk(1,1,8'h12, 0,0,8'h00, 0, 1,0,0, 3'd3, 16'd0, 0,0));
        tbl.push_back(mk(1,1,8'h13, 0,0,8'h00, 0, 0,0,0, 3'd4, 16'd0, 0,0));
        tbl.push_back(mk(1,1,8'h14, 0,0,8'h00, 0, 0,0,0, 3'd4, 16'd0, 0,0));
        tbl.push_back(mk(0,0,8'h00, 1,1,8'h10, 0, 1,0,0, 3'd3, 16'd0, 0,0));
        tbl.push_back(mk(1,1,8'h20, 1,1,8'h11, 0, 1,0,0, 3'd3, 16'd0, 0,0));
        tbl.push_back(mk(0,0,8'h00, 1,1,8'h12, 0, 1,0,0, 3'd2, 16'd0, 0,0));
        tbl.push_back(mk(0,0,8'h00, 1,1,8'h13, 0, 1,0,0, 3'd1, 16'd0, 0,0));
        tbl.push_back(mk(0,0,8'h00, 1,1,8'h20, 0, 1,0,0, 3'd0, 16'd0, 0,0));
        tbl.push_back(mk(1,0,8'h30, 0,0,8'h00, 0, 1,0,0, 3'd1, 16'd0, 0,0));
        tbl.push_back(mk(1,0,8'h31, 0,0,8'h00, 0, 1,0,0, 3'd2, 16'd0, 0,0));
        tbl.push_back(mk(1,0,8'h32, 0,0,8'h00, 0, 1,0,0, 3'd3, 16'd0, 0,0));
        tbl.push_back(mk(0,0,8'h00, 1,1,8'h30, 0, 0,1,1, 3'd0, 16'd1, 0,1));
        tbl.push_back(mk(0,0,8'h00, 0,0,8'h00, 0, 0,1,1, 3'd0, 16'd1, 0,0));
        tbl.push_back(mk(0,0,8'h00, 0,0,8'h00, 0, 0,1,1, 3'd0, 16'd1, 0,0));
        tbl.push_back(mk(0,0,8'h00, 0,0,8'h00, 0, 0,1,1, 3'd0, 16'd1, 0,0));
        tbl.push_back(mk(0,0,8'h00, 0,0,8'h00, 0, 0,1,1, 3'd0, 16'd1, 0,0));
        tbl.push_back(mk(0,0,8'h00, 0,0,8'h00, 1, 1,0,0, 3'd0, 16'd1, 0,0));
        tbl.push_back(mk(0,0,8'h00, 0,0,8'h00, 1, 1,0,0, 3'd0, 16'd1, 0,0));
        tbl.push_back(mk(0,0,8'h00, 1,0,8'h99, 0, 1,0,0, 3'd0, 16'd1, 1,0));
        tbl.push_back(mk(1,0,8'h50, 0,0,8'h00, 0, 1,0,0, 3'd1, 16'd1, 1,0));
        tbl.push_back(mk(1,1,8'h51, 1,1,8'h50, 0, 0,1,1, 3'd0, 16'd2, 1,1));
        tbl.push_back(mk(0,0,8'h00, 0,0,8'h00, 1, 1,0,0, 3'd0, 16'd2, 1,0));

        #1;
        doReset();
        checkOutput("reset ready",    32'(h_ready), 32'd1);
        checkOutput("reset redirect", 32'(h_redir), 32'd0);
        checkOutput("reset rtaken",   32'(h_rtk),   32'd0);
        checkOutput("reset occ",      32'(h_occ),   32'd0);
        checkOutput("reset cnt",      32'(h_cnt),   32'd0);
        checkOutput("reset err",      32'(h_err),   32'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            applyStimulus(v.pv, v.pt, v.ptag, v.rv, v.rt, v.rtag, v.ack);
            checkOutput($sformatf("row%0d ready", i),    32'(h_ready), 32'(v.ready));
            checkOutput($sformatf("row%0d redirect", i), 32'(h_redir), 32'(v.redir));
            if (v.redir) begin
                checkOutput($sformatf("row%0d rtaken", i), 32'(h_rtk), 32'(v.rtk));
            end
            checkOutput($sformatf("row%0d occ", i),      32'(h_occ),   32'(v.occ));
            checkOutput($sformatf("row%0d cnt", i),      32'(h_cnt),   32'(v.cnt));
            checkOutput($sformatf("row%0d err", i),      32'(h_err),   32'(v.err));
            checkOutput($sformatf("row%0d pulse_redirect", i), 32'(p_redir), 32'(v.predir));
        end

        // Tag mismatch with matching direction: error only, no redirect, sticky until reset.
        doReset();
        applyStimulus(1'b1, 1'b1, 8'h54, 1'b0, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h55, 1'b0);
        checkOutput("tagmis err",      32'(h_err),   32'd1);
        checkOutput("tagmis redirect", 32'(h_redir), 32'd0);
        checkOutput("tagmis occ",      32'(h_occ),   32'd0);
        repeat (3) idle(1'b0);
        checkOutput("tagmis err held", 32'(h_err), 32'd1);
        doReset();
        checkOutput("err cleared by reset", 32'(h_err), 32'd0);

        // Resolve arriving while the hold-mode tracker is redirecting.
        applyStimulus(1'b1, 1'b0, 8'h60, 1'b0, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h60, 1'b0);
        checkOutput("redir-res before err", 32'(h_err), 32'd0);
        applyStimulus(1'b1, 1'b0, 8'h61, 1'b1, 1'b0, 8'h61, 1'b0);
        checkOutput("redir-res err",      32'(h_err),   32'd1);
        checkOutput("redir-res redirect", 32'(h_redir), 32'd1);
        checkOutput("redir-res occ",      32'(h_occ),   32'd0);
        checkOutput("redir-res cnt",      32'(h_cnt),   32'd1);
        idle(1'b1);
        checkOutput("redir-res ack", 32'(h_redir), 32'd0);

        // Five mistakes against a 2-bit counter, with fetch_ack held so each redirect is short.
        doReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1, 8'h70, 1'b0, 1'b0, 8'h00, 1'b1);
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h70, 1'b1);
            exp_cnt = (i + 1 > 3) ? 3 : i + 1;
            checkOutput($sformatf("sat%0d redirect", i), 32'(s_redir), 32'd1);
            checkOutput($sformatf("sat%0d rtaken", i),   32'(s_rtk),   32'd0);
            checkOutput($sformatf("sat%0d cnt", i),      32'(s_cnt),   32'(exp_cnt));
            idle(1'b1);
            checkOutput($sformatf("sat%0d drop", i),     32'(s_redir), 32'd0);
        end
        checkOutput("nosat cnt", 32'(h_cnt), 32'd5);

        // Asynchronous reset in the middle of a redirect.
        applyStimulus(1'b1, 1'b1, 8'h71, 1'b0, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h71, 1'b0);
        checkOutput("midrst pre redirect", 32'(s_redir), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst redirect", 32'(s_redir), 32'd0);
        checkOutput("midrst occ",      32'(s_occ),   32'd0);
        checkOutput("midrst cnt",      32'(s_cnt),   32'd0);
        doReset();

        // Asynchronous reset with entries still queued.
        applyStimulus(1'b1, 1'b1, 8'h80, 1'b0, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'h81, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("qrst pre occ", 32'(h_occ), 32'd2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("qrst occ",   32'(h_occ),   32'd0);
        checkOutput("qrst ready", 32'(h_ready), 32'd1);
        doReset();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
